// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pkg: shared state encoding and default widths for the fetch stage.
// Rev 1.0
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int OPCODE_W    = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_PC_STEP = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_VALID = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit_if: instruction-memory, decode and redirect signals of the fetch stage.
// Rev 1.0
// ----------------------------------------------------------------------------
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);
  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_rdata;
  logic [INSTR_W-1:0]  instr;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   pc_out;
  logic                instr_valid;
  logic                instr_ready;
  logic                redirect;
  logic [ADDR_W-1:0]   redirect_pc;
  logic                fetch_err;

  modport master (
    output imem_req, imem_addr, instr, opcode, pc_out, instr_valid, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, pc_out, instr_valid, fetch_err,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_pc_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_reg: program counter with reset, sequential increment and priority load.
// Rev 1.0
// ----------------------------------------------------------------------------
module pc_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                PC_STEP  = DEF_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_load,
  input  wire logic [ADDR_W-1:0] i_load_pc,
  input  wire logic              i_inc,
  output logic      [ADDR_W-1:0] o_pc,
  output logic      [ADDR_W-1:0] o_pc_next
);
  logic [ADDR_W-1:0] r_pc;

  // Wraps modulo 2^ADDR_W by construction.
  assign o_pc_next = r_pc + ADDR_W'(PC_STEP);
  assign o_pc      = r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= o_pc_next;
    end
  end
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit: PC, imem req/ack fetch and redirect handling; FETCH_TIMEOUT_EN adds ack timeout/HALT.
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                INSTR_W     = DEF_INSTR_W,
  parameter int                PC_STEP     = DEF_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 255
) (
  input wire logic      clk,
  input wire logic      rst,
  fetch_unit_if.master  bus
);
  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_req_addr;
  logic [ADDR_W-1:0]  r_pc_out;
  logic [INSTR_W-1:0] r_instr;
  logic               r_imem_req;
  logic               r_instr_valid;
  logic [ADDR_W-1:0]  w_pc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic               w_timeout;
  logic               w_pc_load;
  logic               w_pc_inc;

  // Timeout outranks redirect so a dead memory always lands in HALT.
  assign w_pc_load = bus.redirect && (r_state != ST_HALT) && !w_timeout;
  assign w_pc_inc  = (r_state == ST_VALID) && bus.instr_ready;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_pc_load),
    .i_load_pc (bus.redirect_pc),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc),
    .o_pc_next (w_pc_next)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_fetch_err;

  assign w_timeout     = r_imem_req && !bus.imem_ack && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign bus.fetch_err = r_fetch_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt   <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (!r_imem_req || bus.imem_ack || (bus.redirect && r_state == ST_REQ)) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout     = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_req_addr    <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_pc_out      <= RESET_PC;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_REQ;
          r_imem_req <= 1'b1;
          if (bus.redirect) r_req_addr <= bus.redirect_pc;
        end
        ST_REQ: begin
          if (w_timeout) begin
            r_state    <= ST_HALT;
            r_imem_req <= 1'b0;
          end else if (bus.redirect) begin
            // Without an ack the old request must still complete, so drain it.
            if (bus.imem_ack) r_req_addr <= bus.redirect_pc;
            else              r_state    <= ST_DRAIN;
          end else if (bus.imem_ack) begin
            r_instr       <= bus.imem_rdata;
            r_pc_out      <= r_req_addr;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (bus.redirect || bus.instr_ready) begin
            r_req_addr    <= bus.redirect ? bus.redirect_pc : w_pc_next;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (w_timeout) begin
            r_state    <= ST_HALT;
            r_imem_req <= 1'b0;
          end else if (bus.imem_ack) begin
            r_req_addr <= bus.redirect ? bus.redirect_pc : w_pc;
            r_state    <= ST_REQ;
          end
        end
        ST_HALT: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_req_addr;
  assign bus.instr       = r_instr;
  assign bus.opcode      = r_instr[INSTR_W-1 -: OPCODE_W];
  assign bus.pc_out      = r_pc_out;
  assign bus.instr_valid = r_instr_valid;
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_unit: directed stimulus with queued expectations checked by a monitor.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   t_prev = 0;

  logic [31:0] q_addr[$];
  exp_t        q_instr[$];
  logic [31:0] m_addr;
  exp_t        m_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  fetch_unit #(
    .ADDR_W      (32),
    .INSTR_W     (32),
    .PC_STEP     (4),
    .RESET_PC    (32'h0),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.imem_req && n < 50) begin
      tick();
      n++;
    end
    if (!bus.imem_req) begin
      n_chk++;
      $display("FAIL wait_req: imem_req=0 after 50 cycles, expected 1");
    end
  endtask

  task automatic do_ack(input logic [31:0] data);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
  endtask

  // Scoreboard monitor: memory handshakes and decode handshakes.
  always @(negedge clk) begin
    if (bus.imem_req && bus.imem_ack) begin
      if (q_addr.size() == 0) begin
        n_chk++;
        $display("FAIL ack_addr: unexpected ack at %0h, expected none", bus.imem_addr);
      end else begin
        m_addr = q_addr.pop_front();
        chk("ack_addr", bus.imem_addr, m_addr);
      end
    end
    if (bus.instr_valid && bus.instr_ready) begin
      if (q_instr.size() == 0) begin
        n_chk++;
        $display("FAIL issue: unexpected instr %0h, expected none", bus.instr);
      end else begin
        m_exp = q_instr.pop_front();
        chk("issue_instr", bus.instr, m_exp.instr);
        chk("issue_opcode", bus.opcode, m_exp.instr[31:28]);
        chk("issue_pc_out", bus.pc_out, m_exp.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset, with a stray ack that must be ignored.
    tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    tick();
    bus.imem_ack   = 1'b0;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_opcode", bus.opcode, 4'h0);
    chk("rst_pc_out", bus.pc_out, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_err", bus.fetch_err, 1'b0);
    rst = 1'b0;

    // First fetch, one-cycle ack-to-valid latency.
    wait_req();
    q_addr.push_back(32'h0);
    q_instr.push_back('{32'h4000_0000, 32'h0});
    do_ack(32'h4000_0000);
    chk("first_valid", bus.instr_valid, 1'b1);
    chk("first_opcode", bus.opcode, 4'h4);
    chk("first_pc_out", bus.pc_out, 32'h0);

    // Stall: outputs hold, ack outside REQ ignored.
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
      end
      tick();
      bus.imem_ack = 1'b0;
      chk("stall_instr", bus.instr, 32'h4000_0000);
      chk("stall_pc_out", bus.pc_out, 32'h0);
      chk("stall_req", bus.imem_req, 1'b0);
      chk("stall_valid", bus.instr_valid, 1'b1);
    end

    // Sequential stream, ack one cycle after request.
    bus.instr_ready = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      q_addr.push_back(32'(4 * k));
      q_instr.push_back('{32'h1000_0000 * k + 32'(4 * k), 32'(4 * k)});
      wait_req();
      tick();
      do_ack(32'h1000_0000 * k + 32'(4 * k));
      if (k >= 2) chk("issue_interval", cyc - t_prev, 3);
      t_prev = cyc;
    end

    // Redirect in VALID with ready also high.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    chk("rdv_addr", bus.imem_addr, 32'h100);
    chk("rdv_valid", bus.instr_valid, 1'b0);
    q_addr.push_back(32'h100);
    q_instr.push_back('{32'h5000_0100, 32'h100});
    do_ack(32'h5000_0100);
    tick();
    chk("after_rdv_addr", bus.imem_addr, 32'h104);

    // Redirect mid-fetch: drain old request, then fetch target.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    bus.redirect = 1'b0;
    chk("drain_req", bus.imem_req, 1'b1);
    chk("drain_addr", bus.imem_addr, 32'h104);
    tick();
    tick();
    q_addr.push_back(32'h104);
    do_ack(32'hFFFF_FFFF);
    chk("drain_drop_valid", bus.instr_valid, 1'b0);
    chk("drain_next_addr", bus.imem_addr, 32'h200);

    // Second redirect during DRAIN wins.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    tick();
    bus.redirect = 1'b0;
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h400;
    tick();
    bus.redirect = 1'b0;
    q_addr.push_back(32'h200);
    do_ack(32'hFFFF_FFFF);
    chk("drain2_valid", bus.instr_valid, 1'b0);
    chk("drain2_addr", bus.imem_addr, 32'h400);

    // Redirect and ack together in REQ: data discarded.
    q_addr.push_back(32'h400);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h500;
    do_ack(32'h9999_9999);
    bus.redirect = 1'b0;
    chk("reqack_addr", bus.imem_addr, 32'h500);
    chk("reqack_req", bus.imem_req, 1'b1);
    tick();
    chk("reqack_valid", bus.instr_valid, 1'b0);

    // Wrap: fetch at 0xFFFF_FFFC, consume, next address 0.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    q_addr.push_back(32'h500);
    do_ack(32'h0BAD_0BAD);
    chk("wrap_req_addr", bus.imem_addr, 32'hFFFF_FFFC);
    q_addr.push_back(32'hFFFF_FFFC);
    q_instr.push_back('{32'h7000_0000, 32'hFFFF_FFFC});
    do_ack(32'h7000_0000);
    tick();
    chk("wrap_next_addr", bus.imem_addr, 32'h0);
    q_addr.push_back(32'h0);
    q_instr.push_back('{32'h8000_0000, 32'h0});
    do_ack(32'h8000_0000);
    tick();
    chk("post_wrap_addr", bus.imem_addr, 32'h4);

`ifdef FETCH_TIMEOUT_EN
    repeat (7) tick();
    chk("tmo_err_early", bus.fetch_err, 1'b0);
    chk("tmo_req_early", bus.imem_req, 1'b1);
    tick();
    chk("tmo_err", bus.fetch_err, 1'b1);
    chk("tmo_req", bus.imem_req, 1'b0);
    chk("tmo_valid", bus.instr_valid, 1'b0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h600;
    tick();
    bus.redirect = 1'b0;
    tick();
    chk("halt_req", bus.imem_req, 1'b0);
    chk("halt_err", bus.fetch_err, 1'b1);
`else
    repeat (20) tick();
    chk("no_tmo_err", bus.fetch_err, 1'b0);
    chk("no_tmo_req", bus.imem_req, 1'b1);
    chk("no_tmo_addr", bus.imem_addr, 32'h4);
`endif

    tick();
    chk("addr_queue_empty", q_addr.size(), 0);
    chk("instr_queue_empty", q_instr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
